multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
//
// PURPOSE
//   Multi-cycle control FSM that sequences one instruction at a time through the
//   FETCH, DECODE, EXEC, MEM and WB states. It drives datapath control strobes
//   per state and runs valid/ack handshakes with instruction and data memory.
//   Compared with the combinational decoder it adds the following:
//   - parametrised opcode width
//   - memory timeout detection
//   - illegal-opcode trapping
//   - run/idle control
//   - a retired-instruction counter
//   It sits between the IR/ALU datapath and the memories.
//
// PARAMETERS
//   OPW         3    opcode width; codes >= 8 are illegal (only when OPW > 3)
//   MEM_TIMEOUT 15   max cycles to wait for an ack before ERR; must be >= 1
//   CNT_W       16   width of retire_cnt
//
// PORTS
//   clk         in   1      clock, rising edge
//   rst_n       in   1      async active-low reset
//   run         in   1      level: enables fetching of new instructions
//   opcode      in   OPW    opcode field of the IR; stable from DECODE onward
//   zero        in   1      ALU zero flag, sampled in EXEC for beq
//   imem_ack    in   1      instruction memory done; IR data valid this cycle
//   dmem_ack    in   1      data memory access done
//   imem_req    out  1      instruction fetch request
//   dmem_req    out  1      data access request
//   ir_write    out  1      load the IR
//   pc_write    out  1      update the PC
//   pc_src      out  2      0 = PC+1, 1 = branch target, 2 = jump target
//   reg_write   out  1      register file write enable
//   mem_read    out  1      data memory read
//   mem_write   out  1      data memory write
//   alu_op      out  2      00 add, 01 xor, 10 sll, 11 slt
//   alu_src     out  1      1 = immediate operand
//   reg_dst     out  1      1 = rd field selects the write register
//   mem_to_reg  out  1      1 = write-back data comes from memory
//   busy        out  1      FSM is not in IDLE and not in ERR
//   err         out  1      sticky error; set in ERR, cleared only by reset
//   retired     out  1      1-cycle pulse when an instruction completes
//   retire_cnt  out  CNT_W  count of retired instructions; wraps to 0
//
// BEHAVIOUR
// - Reset: state = IDLE. Every output is 0. The timeout counter and retire_cnt are 0.
// - Opcodes: 0 add, 1 xor, 2 sll, 3 slt, 4 j, 5 sw, 6 lw, 7 beq.
//   The opcode class is registered in DECODE; later states use the registered copy.
// - Outputs are combinational from the state and the registered class.
//   Any output not listed for a state is 0.
// - IDLE: go to FETCH when run = 1.
// - FETCH: imem_req = 1.
//   - imem_ack = 1: ir_write = 1, pc_write = 1, pc_src = 0; go to DECODE.
//   - Otherwise stay in FETCH.
// - DECODE: register the class.
//   - Illegal opcode: go to ERR. Otherwise go to EXEC.
// - EXEC:
//   - ALU ops: drive alu_op per the opcode map, alu_src = 0; go to WB.
//   - lw/sw: alu_op = 00, alu_src = 1; go to MEM.
//   - j: pc_write = 1, pc_src = 2; retire.
//   - beq: alu_op = 00 (compare via subtract path in ALU);
//     pc_write = zero, pc_src = 1; retire.
// - MEM: dmem_req = 1; mem_read = 1 for lw, mem_write = 1 for sw.
//   - On dmem_ack: sw retires; lw goes to WB.
// - WB: reg_write = 1, reg_dst = 1; mem_to_reg = 1 for lw only; retire.
// - Retire: retired = 1 in that cycle and retire_cnt increments by 1.
//   Next state is FETCH if run = 1, else IDLE.
// - run = 0 mid-instruction: the current instruction completes normally,
//   then the FSM goes to IDLE.
// - Latency from FETCH entry to retire, with ack on the first request cycle:
//   - ALU ops: 4 cycles
//   - lw: 5 cycles
//   - sw: 4 cycles
//   - j/beq: 3 cycles
//   Each wait cycle in FETCH or MEM adds 1.
// - Timeout counter:
//   - Clears on entry to FETCH or MEM.
//   - Increments on each cycle in FETCH or MEM without an ack.
//   - Reaching MEM_TIMEOUT goes to ERR.
//   - If ack arrives in the same cycle the count reaches MEM_TIMEOUT,
//     ack wins and there is no error.
// - ERR: err = 1; all strobes and reqs are 0. Exit only through rst_n.
// - Async reset mid-instruction: outputs go to their reset values immediately.
//   No partial write strobe may persist after rst_n falls.
// - retire_cnt: all-ones + 1 wraps to 0; err is not affected.
//
// TESTING
// 1. add (op 0), run = 1, acks on first request -> ir_write in cycle 1;
//    reg_write = 1, alu_op = 00 in cycle 4; retired pulse; retire_cnt = 1.
// 2. lw (op 6) with dmem_ack delayed 3 cycles -> mem_read held for 4 cycles,
//    then WB with mem_to_reg = 1; total latency 8 cycles.
// 3. beq (op 7) with zero = 1 -> pc_write = 1, pc_src = 1 in EXEC;
//    with zero = 0 -> pc_write = 0 in EXEC; both retire.
// 4. imem_ack never asserted, MEM_TIMEOUT = 15 -> ERR after 15 cycles;
//    err = 1 and stays 1; busy = 0.
//    Variant: ack in cycle 15 -> no error.
// 5. OPW = 4, opcode = 4'b1001 -> DECODE goes to ERR; no reg_write or mem_write.
// 6. run dropped during sw MEM wait -> sw completes, then IDLE.
//    rst_n pulsed during lw MEM -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with
// memory handshakes, timeout and illegal-opcode trapping, and a retire counter.
module multicycle_ctrl #(
  parameter int OPW         = 3,   // must be >= 3
  parameter int MEM_TIMEOUT = 15,  // must be >= 1
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OPW-1:0]   opcode,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             busy,
  output logic             err,
  output logic             retired,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD, OP_XOR, OP_SLL, OP_SLT, OP_J, OP_SW, OP_LW, OP_BEQ
  } op_e;

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_e        state, state_next;
  op_e           op_q, op_next;
  logic [TW-1:0] tcnt, tcnt_next;
  logic          illegal;
  logic          timeout;

  if (OPW > 3) begin : g_wide_op
    assign illegal = |opcode[OPW-1:3];
  end else begin : g_narrow_op
    assign illegal = 1'b0;
  end

  // The ack that would have been the MEM_TIMEOUT-th miss still wins.
  assign timeout = (tcnt == TW'(MEM_TIMEOUT - 1));

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the async reset clears outputs without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= OP_ADD;
      tcnt       <= '0;
      retire_cnt <= '0;
    end else begin
      state <= state_next;
      op_q  <= op_next;
      tcnt  <= tcnt_next;
      if (retired) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    op_next    = op_q;
    tcnt_next  = '0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = 2'd0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    err        = 1'b0;
    retired    = 1'b0;

    unique case (state)
      S_IDLE: if (run) state_next = S_FETCH;

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_ERR;
        end else begin
          tcnt_next = tcnt + TW'(1);
        end
      end

      S_DECODE: begin
        op_next    = op_e'(opcode[2:0]);
        state_next = illegal ? S_ERR : S_EXEC;
      end

      S_EXEC: begin
        unique case (op_q)
          OP_ADD, OP_XOR, OP_SLL, OP_SLT: begin
            alu_op     = 2'(op_q);
            state_next = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src    = 1'b1;
            state_next = S_MEM;
          end
          OP_J: begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            retired  = 1'b1;
          end
          OP_BEQ: begin
            pc_write = zero;
            pc_src   = 2'd1;
            retired  = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        dmem_req  = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if (dmem_ack) begin
          if (op_q == OP_SW) retired    = 1'b1;
          else               state_next = S_WB;
        end else if (timeout) begin
          state_next = S_ERR;
        end else begin
          tcnt_next = tcnt + TW'(1);
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = (op_q == OP_LW);
        retired    = 1'b1;
      end

      S_ERR: err = 1'b1;

      default: state_next = S_IDLE;
    endcase

    if (retired) state_next = run ? S_FETCH : S_IDLE;
  end

  assign busy = (state != S_IDLE) && (state != S_ERR);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: a per-instruction timeline
// model predicts every cycle's control outputs and the retire count.
module tb_multicycle_ctrl;

  localparam int OPW  = 4;
  localparam int TMO  = 15;
  localparam int CW   = 4;

  typedef struct packed {
    logic       imem_req, dmem_req, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, mem_read, mem_write;
    logic [1:0] alu_op;
    logic       alu_src, reg_dst, mem_to_reg, busy, err, retired;
  } outs_t;

  logic           clk = 1'b0;
  logic           rst_n, run, zero, imem_ack, dmem_ack;
  logic [OPW-1:0] opcode;
  logic           imem_req, dmem_req, ir_write, pc_write, reg_write;
  logic           mem_read, mem_write, alu_src, reg_dst, mem_to_reg;
  logic           busy, err, retired;
  logic [1:0]     pc_src, alu_op;
  logic [CW-1:0]  retire_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int model_cnt = 0;
  bit in_idle = 1'b1;

  multicycle_ctrl #(.OPW(OPW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_op(alu_op), .alu_src(alu_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .busy(busy), .err(err),
    .retired(retired), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic outs_t observed();
    outs_t o;
    o.imem_req = imem_req;   o.dmem_req = dmem_req;   o.ir_write = ir_write;
    o.pc_write = pc_write;   o.pc_src = pc_src;       o.reg_write = reg_write;
    o.mem_read = mem_read;   o.mem_write = mem_write; o.alu_op = alu_op;
    o.alu_src = alu_src;     o.reg_dst = reg_dst;     o.mem_to_reg = mem_to_reg;
    o.busy = busy;           o.err = err;             o.retired = retired;
    return o;
  endfunction

  // Inputs are already set (posedge+1); check mid-cycle, then advance.
  task automatic cycle(input outs_t e, input string tag);
    @(negedge clk);
    check(tag, 32'(observed()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    check(tag, 32'(retire_cnt), 32'(model_cnt % (1 << CW)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    zero = 1'b0; opcode = '0;
    #2;
    check("reset_outs", 32'(observed()), 32'(outs_t'('0)));
    check("reset_cnt", 32'(retire_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_cnt = 0;
    in_idle = 1'b1;
  endtask

  // ERR is sticky regardless of run/acks; only reset leaves it.
  task automatic expect_err();
    outs_t e = '0;
    e.err = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run = 1'b1;
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      cycle(e, "err_sticky");
    end
    check_cnt("err_cnt_kept");
    do_reset();
  endtask

  // One instruction: iw/dw are fetch/data wait cycles (>= TMO means no ack ever),
  // run_after is the run level at retire, rst_mid pulses reset in the MEM phase.
  task automatic do_instr(input logic [OPW-1:0] op, input int iw, input int dw,
                          input logic z, input logic run_after, input bit rst_mid);
    outs_t e;
    bool_mem: begin end
    if (in_idle) begin
      run = 1'b1;
      cycle(outs_t'('0), "idle_go");
      in_idle = 1'b0;
    end
    opcode = op;
    zero   = z;
    for (int k = 0; k < TMO; k++) begin
      imem_ack = (k == iw);
      e = '0; e.imem_req = 1'b1; e.busy = 1'b1;
      if (k == iw) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      cycle(e, "fetch");
      if (k == iw) break;
    end
    imem_ack = 1'b0;
    if (iw >= TMO) begin expect_err(); return; end

    e = '0; e.busy = 1'b1;
    cycle(e, "decode");
    if (op >= 8) begin expect_err(); return; end

    if (op != 5 && op != 6) run = run_after;
    e = '0; e.busy = 1'b1;
    case (op)
      0, 1, 2, 3: e.alu_op = op[1:0];
      4: begin e.pc_write = 1'b1; e.pc_src = 2'd2; e.retired = 1'b1; end
      5, 6: e.alu_src = 1'b1;
      default: begin e.pc_write = z; e.pc_src = 2'd1; e.retired = 1'b1; end
    endcase
    cycle(e, "exec");
    if (e.retired) model_cnt++;

    if (op == 5 || op == 6) begin
      for (int k = 0; k < TMO; k++) begin
        dmem_ack = (k == dw);
        if (k == 0) run = run_after;
        if (rst_mid) begin
          #2 rst_n = 1'b0;
          #1;
          check("async_rst_outs", 32'(observed()), 32'(outs_t'('0)));
          check("async_rst_cnt", 32'(retire_cnt), 32'd0);
          @(posedge clk);
          #1;
          rst_n = 1'b1; run = 1'b0; dmem_ack = 1'b0;
          model_cnt = 0; in_idle = 1'b1;
          cycle(outs_t'('0), "post_rst_idle");
          return;
        end
        e = '0; e.dmem_req = 1'b1; e.busy = 1'b1;
        e.mem_read = (op == 6); e.mem_write = (op == 5);
        if (k == dw && op == 5) e.retired = 1'b1;
        cycle(e, "mem");
        if (k == dw) break;
      end
      dmem_ack = 1'b0;
      if (dw >= TMO) begin expect_err(); return; end
      if (op == 5) model_cnt++;
    end

    if (op < 4 || op == 6) begin
      e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.busy = 1'b1;
      e.mem_to_reg = (op == 6); e.retired = 1'b1;
      cycle(e, "wb");
      model_cnt++;
    end

    check_cnt("retire_cnt");
    if (!run) begin
      cycle(outs_t'('0), "idle_after");
      in_idle = 1'b1;
    end
  endtask

  initial begin
    do_reset();
    cycle(outs_t'('0), "idle_hold");

    do_instr(4'd0, 0, 0, 1'b0, 1'b1, 1'b0);   // add, single-cycle acks
    do_instr(4'd6, 0, 3, 1'b0, 1'b1, 1'b0);   // lw, 3 data wait cycles
    do_instr(4'd7, 0, 0, 1'b1, 1'b1, 1'b0);   // beq taken
    do_instr(4'd7, 1, 0, 1'b0, 1'b1, 1'b0);   // beq not taken
    do_instr(4'd5, 0, 2, 1'b0, 1'b0, 1'b0);   // sw, run dropped in MEM wait
    do_instr(4'd1, TMO - 1, 0, 1'b0, 1'b1, 1'b0); // ack on the last allowed cycle
    do_instr(4'd5, 0, TMO - 1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_instr(OPW'($urandom_range(0, 7)),
               ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) != 0), 1'b0);
    end

    do_instr(4'b1001, 0, 0, 1'b0, 1'b1, 1'b0); // illegal opcode traps
    do_instr(4'd0, TMO, 0, 1'b0, 1'b1, 1'b0);  // fetch timeout
    do_instr(4'd6, 0, TMO, 1'b0, 1'b1, 1'b0);  // data timeout
    do_instr(4'd6, 0, 2, 1'b0, 1'b1, 1'b1);    // reset pulsed during lw MEM

    for (int i = 0; i < 20; i++) begin
      do_instr(OPW'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
